// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the 2-read / 1-write register file: read ports, debug read,
// write-back port and the committed-write counter.
interface reg_file_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [15:0]       wr_count;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
    input  rd_data_a, rd_data_b, dbg_data, wr_count
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
    output rd_data_a, rd_data_b, dbg_data, wr_count
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// Datapath register file: r0 hard-wired to zero, clocked write-back, combinational reads.
// Optional same-cycle write-to-read bypass on ports A/B when REGFILE_BYPASS_EN is defined.
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  reg_file_2r1w_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [15:0]       cnt;
  logic              wr_hit;

  assign wr_hit = bus.wr_en && (bus.wr_addr != '0);

  // mem[0] is only ever loaded by reset, so it stays zero for every read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      cnt <= '0;
    end else if (wr_hit) begin
      mem[bus.wr_addr] <= bus.wr_data;
      if (cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  always_comb begin
    bus.rd_data_a = mem[bus.rd_addr_a];
    bus.rd_data_b = mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    // gated by rst_n so outputs read zero throughout reset
    if (rst_n && wr_hit && (bus.rd_addr_a == bus.wr_addr)) begin
      bus.rd_data_a = bus.wr_data;
    end
    if (rst_n && wr_hit && (bus.rd_addr_b == bus.wr_addr)) begin
      bus.rd_data_b = bus.wr_data;
    end
`endif
  end

  assign bus.dbg_data = mem[bus.dbg_addr];
  assign bus.wr_count = cnt;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: reference model plus scoreboard queue of
// expected read values, compared when the DUT outputs are sampled.
module tb_reg_file_2r1w;
  logic clk;
  logic rst_n;

  reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [32];
  int          mcnt;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got %08h want queued entry", obs);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mcnt = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    if (a != 0) begin
      mdl[a] = d;
      if (mcnt != 16'hFFFF) mcnt++;
    end
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    bus.rd_addr_a = a;
    bus.rd_addr_b = b;
    bus.dbg_addr  = d;
    #1;
    push({tag, "_a"}, mdl[a]);
    push({tag, "_b"}, mdl[b]);
    push({tag, "_dbg"}, mdl[d]);
    pop_chk(bus.rd_data_a);
    pop_chk(bus.rd_data_b);
    pop_chk(bus.dbg_data);
  endtask

  task automatic cnt_chk(input string tag);
    push(tag, 32'(mcnt));
    pop_chk({16'h0, bus.wr_count});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mdl_clear();
    rst_n         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus.dbg_addr  = '0;
    #12;
    rd_chk("rst_init", 5'd1, 5'd31, 5'd0);
    cnt_chk("rst_init_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset mid-cycle after writing r5
    wr(5'd5, 32'hDEADBEEF);
    rd_chk("r5_pre", 5'd5, 5'd5, 5'd5);
    cnt_chk("r5_cnt");
    #2;
    rst_n = 1'b0;
    mdl_clear();
    rd_chk("rst_async", 5'd5, 5'd5, 5'd5);
    cnt_chk("rst_async_cnt");
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr_a = 5'(i);
      bus.rd_addr_b = 5'(31 - i);
      bus.dbg_addr  = 5'(i);
      #1;
      push("rst_all_a", 32'h0);
      push("rst_all_b", 32'h0);
      push("rst_all_dbg", 32'h0);
      pop_chk(bus.rd_data_a);
      pop_chk(bus.rd_data_b);
      pop_chk(bus.dbg_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic write/read
    wr(5'd7, 32'h12345678);
    wr(5'd31, 32'hFFFFFFFF);
    rd_chk("basic", 5'd7, 5'd31, 5'd7);
    cnt_chk("basic_cnt");

    // r0 immunity
    wr(5'd0, 32'hA5A5A5A5);
    rd_chk("r0", 5'd0, 5'd0, 5'd0);
    cnt_chk("r0_cnt");

    // collision
    wr(5'd3, 32'h1);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd3;
    bus.wr_data   = 32'h2;
    bus.rd_addr_a = 5'd3;
    bus.rd_addr_b = 5'd3;
    bus.dbg_addr  = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    push("coll_pre_a", 32'h2);
    push("coll_pre_b", 32'h2);
`else
    push("coll_pre_a", 32'h1);
    push("coll_pre_b", 32'h1);
`endif
    push("coll_pre_dbg", 32'h1);
    pop_chk(bus.rd_data_a);
    pop_chk(bus.rd_data_b);
    pop_chk(bus.dbg_data);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    mdl[3] = 32'h2;
    mcnt++;
    rd_chk("coll_post", 5'd3, 5'd3, 5'd3);
    cnt_chk("coll_cnt");

    // write disable with live address/data
    wr(5'd9, 32'h00000055);
    bus.wr_en   = 1'b0;
    bus.wr_addr = 5'd9;
    bus.wr_data = 32'hCAFEF00D;
    repeat (10) @(posedge clk);
    #1;
    rd_chk("wr_dis", 5'd9, 5'd9, 5'd9);
    cnt_chk("wr_dis_cnt");

    // reset asserted between edges beats a pending write
    wr(5'd4, 32'h44444444);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd4;
    bus.wr_data = 32'h99999999;
    #2;
    rst_n = 1'b0;
    mdl_clear();
    #1;
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_chk("rst_pend", 5'd4, 5'd9, 5'd7);
    cnt_chk("rst_pend_cnt");

    // counter saturation
    for (int i = 0; i < 65540; i++) begin
      wr(5'((i % 31) + 1), 32'(i));
    end
    cnt_chk("sat_cnt");
    rd_chk("sat_data", 5'd1, 5'd17, 5'd31);
    wr(5'd2, 32'h0BADBEEF);
    cnt_chk("sat_hold");
    #2;
    rst_n = 1'b0;
    mdl_clear();
    #1;
    cnt_chk("sat_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wr(5'd6, 32'h66);
    cnt_chk("post_rst_cnt");
    rd_chk("post_rst", 5'd6, 5'd2, 5'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
